// File: rtl/operand_entry_ctrl_if.sv
// Button/switch inputs and decoder-side outputs of the operand entry sequencer.
// The master drives buttons and switches; the slave (operand_entry_ctrl) drives the decoder outputs.
interface operand_entry_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             btn_enter;
  logic             btn_clear;
  logic [WIDTH-1:0] sw_data;
  logic             write_addr;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             operands_ready;
  logic [1:0]       state_dbg;

  modport master (
    output btn_enter, btn_clear, sw_data,
    input  write_addr, load, load_data, operands_ready, state_dbg
  );

  modport slave (
    input  btn_enter, btn_clear, sw_data,
    output write_addr, load, load_data, operands_ready, state_dbg
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Operand A/B entry sequencer: conditions ENTER/CLEAR and drives write_addr/load/load_data.
// Optional button debounce is enabled with the ENTRY_DEBOUNCE_EN macro.
module operand_entry_ctrl #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst,
  operand_entry_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_RDY = 2'b10
  } state_e;

  localparam int unsigned BTN_ENTER = 0;
  localparam int unsigned BTN_CLEAR = 1;

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0] btn_raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] lvl;
  logic [1:0] prev_q;
  logic [1:0] press;

  assign btn_raw = {bus.btn_clear, bus.btn_enter};

  // Two-flop synchroniser plus previous-level flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
    end
  end

`ifdef ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar g = 0; g < 2; g++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (sync2_q[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        lvl_q <= sync2_q[g];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign lvl[g] = lvl_q;
  end
`else
  assign lvl = sync2_q;
`endif

  assign press = lvl & ~prev_q;

  state_e           state_q, state_d;
  logic             load_q, load_d;
  logic             waddr_q, waddr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      load_q  <= 1'b0;
      waddr_q <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  // Clear has priority over enter; address/data hold unless a load is issued.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    ready_d = ready_q;
    if (press[BTN_CLEAR]) begin
      state_d = S_A;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (press[BTN_ENTER]) begin
            load_d  = 1'b1;
            waddr_d = 1'b0;
            data_d  = bus.sw_data;
            state_d = S_B;
          end
        end
        S_B: begin
          if (press[BTN_ENTER]) begin
            load_d  = 1'b1;
            waddr_d = 1'b1;
            data_d  = bus.sw_data;
            state_d = S_RDY;
            ready_d = 1'b1;
          end
        end
        S_RDY: begin
          if (press[BTN_ENTER]) begin
            load_d  = 1'b1;
            waddr_d = 1'b0;
            data_d  = bus.sw_data;
            state_d = S_B;
            ready_d = 1'b0;
          end
        end
        default: begin
          state_d = S_A;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.load           = load_q;
  assign bus.write_addr     = waddr_q;
  assign bus.load_data      = data_q;
  assign bus.operands_ready = ready_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Scoreboard bench for operand_entry_ctrl: drivers push expected loads, a negedge monitor checks them.
module tb_operand_entry_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 16;
`ifdef ENTRY_DEBOUNCE_EN
  localparam int unsigned LAT   = 2 + DEB;
  localparam int unsigned PULSE = DEB + 4;
`else
  localparam int unsigned LAT   = 2;
  localparam int unsigned PULSE = 3;
`endif

  typedef struct {
    logic             addr;
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  operand_entry_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  operand_entry_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every load strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus_if.load === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("load_addr", 32'(bus_if.write_addr), 32'(e.addr));
        chk("load_data", 32'(bus_if.load_data), 32'(e.data));
        if (e.cyc >= 0) chk("load_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Raise ENTER (optionally with CLEAR) on a negedge; button is first sampled at the next edge.
  task automatic press(input logic [WIDTH-1:0] d, input int hold, input bit with_clear,
                       input bit exp_load, input logic exp_addr);
    exp_t e;
    @(negedge clk);
    bus_if.sw_data   = d;
    bus_if.btn_enter = 1'b1;
    bus_if.btn_clear = with_clear;
    if (exp_load) begin
      e.addr = exp_addr;
      e.data = d;
      e.cyc  = cyc + 1 + int'(LAT);
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk);
    bus_if.btn_enter = 1'b0;
    bus_if.btn_clear = 1'b0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk);
    bus_if.btn_clear = 1'b1;
    repeat (PULSE) @(negedge clk);
    bus_if.btn_clear = 1'b0;
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic addr, input logic [WIDTH-1:0] data,
                          input logic rdy, input logic [1:0] st);
    chk({tag, "_load"},  32'(bus_if.load), 32'd0);
    chk({tag, "_addr"},  32'(bus_if.write_addr), 32'(addr));
    chk({tag, "_data"},  32'(bus_if.load_data), 32'(data));
    chk({tag, "_ready"}, 32'(bus_if.operands_ready), 32'(rdy));
    chk({tag, "_state"}, 32'(bus_if.state_dbg), 32'(st));
  endtask

  initial begin
    bus_if.btn_enter = 1'b0;
    bus_if.btn_clear = 1'b0;
    bus_if.sw_data   = '0;
    repeat (3) @(negedge clk);
    chk_outs("in_reset", 1'b0, 4'h0, 1'b0, 2'b00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("after_reset", 1'b0, 4'h0, 1'b0, 2'b00);

    // Two entries: A then B.
    press(4'h5, PULSE, 1'b0, 1'b1, 1'b0);
    chk_outs("after_a", 1'b0, 4'h5, 1'b0, 2'b01);
    press(4'hA, PULSE, 1'b0, 1'b1, 1'b1);
    chk_outs("after_b", 1'b1, 4'hA, 1'b1, 2'b10);

    // Held ENTER in S_RDY: one load only, starts a new entry.
    press(4'h3, 50, 1'b0, 1'b1, 1'b0);
    chk_outs("held_enter", 1'b0, 4'h3, 1'b0, 2'b01);

    press(4'hC, PULSE, 1'b0, 1'b1, 1'b1);
    chk_outs("rdy_again", 1'b1, 4'hC, 1'b1, 2'b10);

    // ENTER and CLEAR together: clear wins, address/data hold.
    press(4'h6, PULSE, 1'b1, 1'b0, 1'b0);
    chk_outs("enter_clear", 1'b1, 4'hC, 1'b0, 2'b00);

    // Clear alone in S_B.
    press(4'h9, PULSE, 1'b0, 1'b1, 1'b0);
    press_clear();
    chk_outs("clear_in_b", 1'b0, 4'h9, 1'b0, 2'b00);

    // Reset pulsed in S_B with sw=7; next entry goes to A.
    press(4'h2, PULSE, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_state", 32'(bus_if.state_dbg), 32'd1);
    bus_if.sw_data = 4'h7;
    #2 rst = 1'b1;
    #1 chk_outs("rst_in_b", 1'b0, 4'h0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    press(4'h7, PULSE, 1'b0, 1'b1, 1'b0);
    chk_outs("after_rst_entry", 1'b0, 4'h7, 1'b0, 2'b01);

    // Reset while load is high kills the strobe immediately.
    begin
      exp_t e;
      int   n;
      @(negedge clk);
      bus_if.sw_data   = 4'hE;
      bus_if.btn_enter = 1'b1;
      e.addr = 1'b1;
      e.data = 4'hE;
      e.cyc  = cyc + 1 + int'(LAT);
      sb.push_back(e);
      n = 0;
      while (bus_if.load !== 1'b1 && n < int'(LAT) + 10) begin
        @(negedge clk);
        n++;
      end
      chk("load_seen_before_rst", 32'(bus_if.load), 32'd1);
      #1 rst = 1'b1;
      #1 chk_outs("rst_during_load", 1'b0, 4'h0, 1'b0, 2'b00);
      bus_if.btn_enter = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      chk_outs("post_rst_idle", 1'b0, 4'h0, 1'b0, 2'b00);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
